hmc_reset_sequencer: RTL and testbench



---
 rtl/hmc_reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_hmc_reset_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hmc_reset_sequencer.sv
// Reset bring-up/recovery sequencer for the HMC controller: orders device, controller and
// user reset release around link training, retrying on link-up timeout or link loss.
module hmc_reset_sequencer #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DEV_WAIT_CYCLES = 8,
  parameter int LINK_TIMEOUT    = 1024,
  parameter int USER_REL_DELAY  = 8,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 16,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk_hmc,
  input  logic          res_n_hmc,
  input  logic          start,
  input  logic          soft_rst_req,
  input  logic          link_up,
  output logic          p_rst_n,
  output logic          ctrl_res_n,
  output logic          user_res_n,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          seq_fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    seq_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOLD     = 3'd1,
    S_DEV_REL  = 3'd2,
    S_CTRL_REL = 3'd3,
    S_USER_REL = 3'd4,
    S_RUN      = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEV_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_REL_DELAY - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_d;
  logic             restart;
  logic             timed;
  logic             p_d, c_d, u_d, busy_d, done_d, fail_d;

  // Next state, retry count and counter
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    restart = 1'b0;
    timed   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || soft_rst_req) begin
          state_d = S_HOLD;
          retry_d = '0;
        end
      end
      S_HOLD: begin
        timed = 1'b1;
        if (cnt_q == HOLD_LAST) state_d = S_DEV_REL;
      end
      S_DEV_REL: begin
        timed = 1'b1;
        if (cnt_q == DEV_LAST) state_d = S_CTRL_REL;
      end
      S_CTRL_REL: begin
        timed = 1'b1;
        if (link_up) begin
          state_d = S_USER_REL;
        end else if (cnt_q == LINK_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + RW'(1);
            state_d = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_USER_REL: begin
        timed = 1'b1;
        // Any drop of link_up while waiting is treated exactly like a link-up timeout
        if (!link_up) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + RW'(1);
            state_d = S_HOLD;
          end else begin
            state_d = S_FAIL;
          end
        end else if (cnt_q == USER_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!link_up) begin
          state_d = S_HOLD;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
        retry_d = '0;
      end
    endcase
    if (soft_rst_req && (state_q != S_IDLE)) begin
      state_d = S_HOLD;
      retry_d = '0;
      restart = 1'b1;
    end
    if ((state_d != state_q) || restart) cnt_d = '0;
    else if (timed)                      cnt_d = cnt_q + CNT_W'(1);
    else                                 cnt_d = cnt_q;
  end

  // Outputs decoded from the next state so they register on the same edge as the state
  always_comb begin
    p_d    = 1'b0;
    c_d    = 1'b0;
    u_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    case (state_d)
      S_HOLD:     busy_d = 1'b1;
      S_DEV_REL:  begin p_d = 1'b1; busy_d = 1'b1; end
      S_CTRL_REL: begin p_d = 1'b1; c_d = 1'b1; busy_d = 1'b1; end
      S_USER_REL: begin p_d = 1'b1; c_d = 1'b1; busy_d = 1'b1; end
      S_RUN:      begin p_d = 1'b1; c_d = 1'b1; u_d = 1'b1; done_d = 1'b1; end
      S_FAIL:     fail_d = 1'b1;
      default:    busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_cnt  <= '0;
      p_rst_n    <= 1'b0;
      ctrl_res_n <= 1'b0;
      user_res_n <= 1'b0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      seq_fail   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_cnt  <= retry_d;
      p_rst_n    <= p_d;
      ctrl_res_n <= c_d;
      user_res_n <= u_d;
      seq_busy   <= busy_d;
      seq_done   <= done_d;
      seq_fail   <= fail_d;
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_hmc_reset_sequencer.sv
// Directed bench for hmc_reset_sequencer: bring-up, retries, FAIL, link loss, glitches,
// soft restart, async reset, and a zero-retry instance.
module tb_hmc_reset_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_HOLD = 3'd1, ST_DEV = 3'd2, ST_CTRL = 3'd3,
                         ST_USER = 3'd4, ST_RUN = 3'd5, ST_FAIL = 3'd6;
  // {p_rst_n, ctrl_res_n, user_res_n, seq_busy, seq_done, seq_fail}
  localparam logic [5:0] O_IDLE = 6'b000000, O_HOLD = 6'b000100, O_DEV = 6'b100100,
                         O_CTRL = 6'b110100, O_USER = 6'b110100, O_RUN = 6'b111010,
                         O_FAIL = 6'b000001;

  logic       clk_hmc = 1'b0;
  logic       res_n_hmc, start, soft_rst_req, link_up;
  logic       p_rst_n, ctrl_res_n, user_res_n, seq_busy, seq_done, seq_fail;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  logic       z_res_n, z_start, z_soft, z_link;
  logic       z_p_rst_n, z_ctrl_res_n, z_user_res_n, z_busy, z_done, z_fail;
  logic [0:0] z_retry;
  logic [2:0] z_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_hmc = ~clk_hmc;

  hmc_reset_sequencer #(.LINK_TIMEOUT(64), .MAX_RETRIES(2)) dut (
    .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc), .start(start), .soft_rst_req(soft_rst_req),
    .link_up(link_up), .p_rst_n(p_rst_n), .ctrl_res_n(ctrl_res_n), .user_res_n(user_res_n),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_fail(seq_fail), .retry_cnt(retry_cnt),
    .seq_state(seq_state)
  );

  hmc_reset_sequencer #(.RST_HOLD_CYCLES(2), .DEV_WAIT_CYCLES(2), .LINK_TIMEOUT(4),
                        .USER_REL_DELAY(2), .MAX_RETRIES(0)) dut_z (
    .clk_hmc(clk_hmc), .res_n_hmc(z_res_n), .start(z_start), .soft_rst_req(z_soft),
    .link_up(z_link), .p_rst_n(z_p_rst_n), .ctrl_res_n(z_ctrl_res_n),
    .user_res_n(z_user_res_n), .seq_busy(z_busy), .seq_done(z_done), .seq_fail(z_fail),
    .retry_cnt(z_retry), .seq_state(z_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [5:0] outs();
    return {p_rst_n, ctrl_res_n, user_res_n, seq_busy, seq_done, seq_fail};
  endfunction

  task automatic expect_state(input string tag, input logic [2:0] st, input logic [5:0] o);
    check({tag, "_state"}, 32'(seq_state), 32'(st));
    check({tag, "_outs"}, 32'(outs()), 32'(o));
  endtask

  // Samples land 1 time unit after the active edge; inputs set afterwards hit the next edge
  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    res_n_hmc = 1'b0; start = 1'b0; soft_rst_req = 1'b0; link_up = 1'b0;
    z_res_n = 1'b0; z_start = 1'b0; z_soft = 1'b0; z_link = 1'b0;
    tick_n(2);
    expect_state("reset", ST_IDLE, O_IDLE);
    check("reset_retry", 32'(retry_cnt), 0);
    res_n_hmc = 1'b1; z_res_n = 1'b1;
    tick();
    expect_state("idle_no_start", ST_IDLE, O_IDLE);

    // Bring-up with default timing: edges counted from the start sample
    start = 1'b1;
    tick();                                   // edge 1
    start = 1'b0;
    expect_state("e1_hold", ST_HOLD, O_HOLD);
    tick_n(15);                               // edge 16
    expect_state("e16_hold", ST_HOLD, O_HOLD);
    tick();                                   // edge 17
    expect_state("e17_dev", ST_DEV, O_DEV);
    tick_n(7);                                // edge 24
    expect_state("e24_dev", ST_DEV, O_DEV);
    tick();                                   // edge 25
    expect_state("e25_ctrl", ST_CTRL, O_CTRL);
    tick_n(14);                               // edge 39
    expect_state("e39_ctrl", ST_CTRL, O_CTRL);
    link_up = 1'b1;
    tick();                                   // edge 40
    expect_state("e40_user", ST_USER, O_USER);
    tick_n(7);                                // edge 47
    expect_state("e47_user", ST_USER, O_USER);
    tick();                                   // edge 48
    expect_state("e48_run", ST_RUN, O_RUN);
    check("e48_retry", 32'(retry_cnt), 0);

    // Link loss in RUN: one low cycle re-sequences, then full bring-up repeats
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    expect_state("linkloss_hold", ST_HOLD, O_HOLD);
    check("linkloss_retry", 32'(retry_cnt), 0);
    tick_n(16);
    expect_state("resq_dev", ST_DEV, O_DEV);
    tick_n(8);
    expect_state("resq_ctrl", ST_CTRL, O_CTRL);
    tick();
    expect_state("resq_user", ST_USER, O_USER);
    tick_n(8);
    expect_state("resq_run", ST_RUN, O_RUN);

    // Soft request from RUN, then a link glitch at USER_REL cycle 3
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_state("soft_from_run", ST_HOLD, O_HOLD);
    tick_n(24);
    expect_state("glitch_ctrl", ST_CTRL, O_CTRL);
    tick();
    expect_state("glitch_user0", ST_USER, O_USER);
    tick_n(2);
    check("glitch_user2_ures", 32'(user_res_n), 0);
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    expect_state("glitch_hold", ST_HOLD, O_HOLD);
    check("glitch_retry", 32'(retry_cnt), 1);

    // Soft request at HOLD cycle 10 restarts the full hold window
    tick_n(10);
    soft_rst_req = 1'b1;
    tick();                                   // request edge
    soft_rst_req = 1'b0;
    expect_state("softhold_hold", ST_HOLD, O_HOLD);
    check("softhold_retry", 32'(retry_cnt), 0);
    tick_n(15);
    expect_state("softhold_15", ST_HOLD, O_HOLD);
    link_up = 1'b0;
    tick();
    expect_state("softhold_16_dev", ST_DEV, O_DEV);
    tick_n(8);
    tick_n(3);
    expect_state("async_pre", ST_CTRL, O_CTRL);
    #2 res_n_hmc = 1'b0;
    #1;
    expect_state("async_rst", ST_IDLE, O_IDLE);
    #2 res_n_hmc = 1'b1;
    tick();
    expect_state("async_after", ST_IDLE, O_IDLE);

    // Three link-up timeouts with MAX_RETRIES=2 end in FAIL
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      tick_n(24);
      expect_state($sformatf("to%0d_ctrl", a), ST_CTRL, O_CTRL);
      tick_n(63);
      expect_state($sformatf("to%0d_last", a), ST_CTRL, O_CTRL);
      tick();
      if (a < 2) begin
        expect_state($sformatf("to%0d_hold", a), ST_HOLD, O_HOLD);
        check($sformatf("to%0d_retry", a), 32'(retry_cnt), 32'(a + 1));
      end else begin
        expect_state("to2_fail", ST_FAIL, O_FAIL);
        check("to2_retry", 32'(retry_cnt), 2);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    expect_state("fail_ignores_start", ST_FAIL, O_FAIL);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_state("fail_soft", ST_HOLD, O_HOLD);
    check("fail_soft_retry", 32'(retry_cnt), 0);

    // One timeout, then link_up rising exactly on the timeout cycle counts as success
    tick_n(24 + 64);
    expect_state("edge_hold", ST_HOLD, O_HOLD);
    check("edge_retry1", 32'(retry_cnt), 1);
    tick_n(24 + 63);
    expect_state("edge_last", ST_CTRL, O_CTRL);
    link_up = 1'b1;
    tick();
    expect_state("edge_user", ST_USER, O_USER);
    check("edge_user_retry", 32'(retry_cnt), 1);
    tick_n(8);
    expect_state("edge_run", ST_RUN, O_RUN);
    check("run_retry_held", 32'(retry_cnt), 1);
    link_up = 1'b0;
    tick();
    expect_state("edge_linkloss", ST_HOLD, O_HOLD);
    check("edge_linkloss_retry", 32'(retry_cnt), 0);

    // MAX_RETRIES=0: first timeout goes straight to FAIL
    z_start = 1'b1;
    tick();
    z_start = 1'b0;
    check("z_hold", 32'(z_state), 32'(ST_HOLD));
    tick_n(4);
    check("z_ctrl", 32'(z_state), 32'(ST_CTRL));
    tick_n(3);
    check("z_ctrl_last", 32'(z_state), 32'(ST_CTRL));
    tick();
    check("z_fail_state", 32'(z_state), 32'(ST_FAIL));
    check("z_fail_outs", 32'({z_p_rst_n, z_ctrl_res_n, z_user_res_n, z_busy, z_done, z_fail}),
          32'(O_FAIL));
    check("z_retry", 32'(z_retry), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
